// File: rtl/riscv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_hazard_ctrl
// Central hazard controller for the 5-stage core. Produces the stall/flush
// controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers plus the PC
// hold. It resolves, in priority order: data-memory wait, multi-cycle mul/div,
// taken branch/jump redirect and load-use. It also keeps a saturating count of
// PC-stall cycles.
//
// Ports
//   clk_i, rst_i (async, active-low)
//   id_rs1_i/id_rs2_i, id_rs1_used_i/id_rs2_used_i : ID-stage source operands
//   ex_rd_i, ex_is_load_i, ex_muldiv_i             : EX-stage instruction info
//   ex_redirect_i                                  : taken branch/jump in EX
//   mem_busy_i                                     : MEM access not complete
//   pc_stall_o, stall_*_o, flush_*_o               : pipeline controls
//   md_busy_o, md_done_o                           : mul/div sequencing status
//   stall_cnt_o                                    : saturating stall counter
// -----------------------------------------------------------------------------
module riscv_hazard_ctrl #(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_is_load_i,
   input  logic        ex_muldiv_i,
   input  logic        ex_redirect_i,
   input  logic        mem_busy_i,
   output logic        pc_stall_o,
   output logic        stall_ifid_o,
   output logic        flush_ifid_o,
   output logic        stall_idex_o,
   output logic        flush_idex_o,
   output logic        stall_exmem_o,
   output logic        flush_exmem_o,
   output logic        stall_memwb_o,
   output logic        flush_memwb_o,
   output logic        md_busy_o,
   output logic        md_done_o,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // The first EX cycle is spent in IDLE, the last one with cnt==0, so the
   // down-counter is loaded with two less than the total occupancy.
   localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 2);
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   md_state_e   state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic lu_haz_s;
   logic md_haz_s;
   logic md_done_s;
   logic pc_stall_s;
   logic stall_ifid_s, flush_ifid_s;
   logic stall_idex_s, flush_idex_s;
   logic stall_exmem_s, flush_exmem_s;
   logic stall_memwb_s, flush_memwb_s;

   // Load-use detection: load in EX writes a register the ID instruction reads.
   always_comb begin
      lu_haz_s = ex_is_load_i & (ex_rd_i != 5'd0) &
                 ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                  (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
   end

   // Mul/div sequencing: next state, down-counter and hazard/done decode.
   // A memory wait freezes EX, so the counter and state hold while busy.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_haz_s  = 1'b0;
      md_done_s = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (ex_muldiv_i) begin
               md_haz_s = 1'b1;
               if (!mem_busy_i) begin
                  cnt_d   = MD_LOAD;
                  state_d = MD_BUSY;
               end else begin
                  cnt_d   = cnt_q;
                  state_d = MD_IDLE;
               end
            end else begin
               md_haz_s = 1'b0;
            end
         end
         MD_BUSY: begin
            if (cnt_q != 8'd0) begin
               md_haz_s = 1'b1;
               if (!mem_busy_i) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               md_haz_s = 1'b0;
               if (!mem_busy_i) begin
                  md_done_s = 1'b1;
                  state_d   = MD_IDLE;
               end else begin
                  md_done_s = 1'b0;
                  state_d   = MD_BUSY;
               end
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Prioritised stall/flush generation; never stall and flush one register.
   always_comb begin
      pc_stall_s    = 1'b0;
      stall_ifid_s  = 1'b0;
      flush_ifid_s  = 1'b0;
      stall_idex_s  = 1'b0;
      flush_idex_s  = 1'b0;
      stall_exmem_s = 1'b0;
      flush_exmem_s = 1'b0;
      stall_memwb_s = 1'b0;
      flush_memwb_s = 1'b0;
      if (!rst_i) begin
         pc_stall_s = 1'b0;
      end else if (mem_busy_i) begin
         // Freeze everything up to MEM; the redirect stays pending in EX.
         pc_stall_s    = 1'b1;
         stall_ifid_s  = 1'b1;
         stall_idex_s  = 1'b1;
         stall_exmem_s = 1'b1;
         flush_memwb_s = 1'b1;
      end else if (md_haz_s) begin
         pc_stall_s    = 1'b1;
         stall_ifid_s  = 1'b1;
         stall_idex_s  = 1'b1;
         flush_exmem_s = 1'b1;
      end else if (ex_redirect_i) begin
         // Wins over load-use: the dependent ID instruction is discarded.
         flush_ifid_s = 1'b1;
         flush_idex_s = 1'b1;
      end else if (lu_haz_s) begin
         pc_stall_s   = 1'b1;
         stall_ifid_s = 1'b1;
         flush_idex_s = 1'b1;
      end else begin
         pc_stall_s = 1'b0;
      end
   end

   // Saturating stall-cycle counter next value.
   always_comb begin
      if (pc_stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers: mul/div FSM, its counter and the stall counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= MD_IDLE;
         cnt_q       <= 8'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pc_stall_o    = pc_stall_s;
   assign stall_ifid_o  = stall_ifid_s;
   assign flush_ifid_o  = flush_ifid_s;
   assign stall_idex_o  = stall_idex_s;
   assign flush_idex_o  = flush_idex_s;
   assign stall_exmem_o = stall_exmem_s;
   assign flush_exmem_o = flush_exmem_s;
   assign stall_memwb_o = stall_memwb_s;
   assign flush_memwb_o = flush_memwb_s;
   assign md_busy_o     = rst_i & (state_q == MD_BUSY);
   assign md_done_o     = rst_i & md_done_s;
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for riscv_hazard_ctrl. Two instances share the stimulus: one with
// MULDIV_CYCLES=4 and one with MULDIV_CYCLES=8 (used for the reset-mid-busy
// sequence). Expected output vectors are pushed to a scoreboard queue when a
// step is driven and popped/compared when the outputs are sampled.
// Output vector bit order:
//   {pc_stall, stall_ifid, flush_ifid, stall_idex, flush_idex,
//    stall_exmem, flush_exmem, stall_memwb, flush_memwb, md_busy, md_done}
// -----------------------------------------------------------------------------
module tb_riscv_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [4:0] id_rs1_i = 5'd0;
   logic [4:0] id_rs2_i = 5'd0;
   logic       id_rs1_used_i = 1'b0;
   logic       id_rs2_used_i = 1'b0;
   logic [4:0] ex_rd_i = 5'd0;
   logic       ex_is_load_i = 1'b0;
   logic       ex_muldiv_i = 1'b0;
   logic       ex_redirect_i = 1'b0;
   logic       mem_busy_i = 1'b0;

   logic [10:0] obs4, obs8;
   logic [31:0] cnt4, cnt8;

   logic a_pc, a_sifid, a_fifid, a_sidex, a_fidex, a_sexm, a_fexm, a_smw, a_fmw, a_busy, a_done;
   logic b_pc, b_sifid, b_fifid, b_sidex, b_fidex, b_sexm, b_fexm, b_smw, b_fmw, b_busy, b_done;

   always #5 clk_i = ~clk_i;

   riscv_hazard_ctrl #(.MULDIV_CYCLES(4)) u_dut4 (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i), .ex_muldiv_i(ex_muldiv_i),
      .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
      .pc_stall_o(a_pc), .stall_ifid_o(a_sifid), .flush_ifid_o(a_fifid),
      .stall_idex_o(a_sidex), .flush_idex_o(a_fidex),
      .stall_exmem_o(a_sexm), .flush_exmem_o(a_fexm),
      .stall_memwb_o(a_smw), .flush_memwb_o(a_fmw),
      .md_busy_o(a_busy), .md_done_o(a_done), .stall_cnt_o(cnt4)
   );

   riscv_hazard_ctrl #(.MULDIV_CYCLES(8)) u_dut8 (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i), .ex_muldiv_i(ex_muldiv_i),
      .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
      .pc_stall_o(b_pc), .stall_ifid_o(b_sifid), .flush_ifid_o(b_fifid),
      .stall_idex_o(b_sidex), .flush_idex_o(b_fidex),
      .stall_exmem_o(b_sexm), .flush_exmem_o(b_fexm),
      .stall_memwb_o(b_smw), .flush_memwb_o(b_fmw),
      .md_busy_o(b_busy), .md_done_o(b_done), .stall_cnt_o(cnt8)
   );

   assign obs4 = {a_pc, a_sifid, a_fifid, a_sidex, a_fidex, a_sexm, a_fexm, a_smw, a_fmw, a_busy, a_done};
   assign obs8 = {b_pc, b_sifid, b_fifid, b_sidex, b_fidex, b_sexm, b_fexm, b_smw, b_fmw, b_busy, b_done};

   typedef struct {
      string       tag;
      logic [10:0] out;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passed = 0;
   logic [31:0] exp_cnt = 32'd0;

   // Expected vectors
   localparam logic [10:0] E_NONE = 11'b000_0000_0000;
   localparam logic [10:0] E_LU   = 11'b110_0100_0000;
   localparam logic [10:0] E_RDIR = 11'b001_0100_0000;
   localparam logic [10:0] E_MEM  = 11'b110_1010_0100;
   localparam logic [10:0] E_MEMB = 11'b110_1010_0110;
   localparam logic [10:0] E_MD0  = 11'b110_1001_0000;
   localparam logic [10:0] E_MDB  = 11'b110_1001_0010;
   localparam logic [10:0] E_DONE = 11'b000_0000_0011;

   // One clock cycle: drive after the rising edge, compare on the falling edge.
   task automatic step(input string tag, input logic sel, input logic rst,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic md,
                       input logic rdir, input logic mb, input logic [10:0] e_out);
      exp_t e, p;
      logic [10:0] o;
      logic [31:0] c;
      @(posedge clk_i);
      #1;
      rst_i = rst;
      id_rs1_i = rs1; id_rs1_used_i = u1;
      id_rs2_i = rs2; id_rs2_used_i = u2;
      ex_rd_i = rd; ex_is_load_i = ld; ex_muldiv_i = md;
      ex_redirect_i = rdir; mem_busy_i = mb;
      if (!rst) exp_cnt = 32'd0;
      e.tag = tag; e.out = e_out; e.cnt = exp_cnt;
      sb_q.push_back(e);
      @(negedge clk_i);
      p = sb_q.pop_front();
      o = sel ? obs8 : obs4;
      c = sel ? cnt8 : cnt4;
      checks++;
      assert (o === p.out) passed++;
      else $error("FAIL %s outputs: observed %b expected %b", p.tag, o, p.out);
      checks++;
      assert (c === p.cnt) passed++;
      else $error("FAIL %s stall_cnt: observed %0d expected %0d", p.tag, c, p.cnt);
      if (p.out[10]) exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic idle(input string tag, input logic sel, input logic [10:0] e_out);
      step(tag, sel, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e_out);
   endtask

   task automatic md(input string tag, input logic sel, input logic mb, input logic [10:0] e_out);
      step(tag, sel, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, mb, e_out);
   endtask

   initial begin
      // Reset state of both instances
      step("reset4", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
      step("reset8", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
      idle("release", 1'b0, E_NONE);

      // Load-use
      step("lu_rs2", 1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
      idle("after_lu", 1'b0, E_NONE);
      step("lu_rd0", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE);
      step("lu_rs1", 1'b0, 1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
      step("lu_unused", 1'b0, 1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE);
      step("lu_noload", 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);

      // Redirect, alone and with a load-use
      step("rdir", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RDIR);
      step("rdir_lu", 1'b0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, E_RDIR);

      // Memory wait, then memory wait with pending redirect for 3 cycles
      step("mem", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_MEM);
      for (int i = 0; i < 3; i++)
         step("mem_rdir", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_MEM);
      step("rdir_after_mem", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RDIR);
      idle("idle1", 1'b0, E_NONE);

      // Mul/div, MULDIV_CYCLES=4
      md("md_c0", 1'b0, 1'b0, E_MD0);
      md("md_c1", 1'b0, 1'b0, E_MDB);
      md("md_c2", 1'b0, 1'b0, E_MDB);
      md("md_c3_done", 1'b0, 1'b0, E_DONE);
      idle("md_after", 1'b0, E_NONE);

      // Mul/div with a 2-cycle memory wait starting at cycle 1, then back-to-back
      md("mdm_c0", 1'b0, 1'b0, E_MD0);
      md("mdm_c1_mem", 1'b0, 1'b1, E_MEMB);
      md("mdm_c2_mem", 1'b0, 1'b1, E_MEMB);
      md("mdm_c3", 1'b0, 1'b0, E_MDB);
      md("mdm_c4", 1'b0, 1'b0, E_MDB);
      md("mdm_c5_done", 1'b0, 1'b0, E_DONE);
      md("b2b_c0", 1'b0, 1'b0, E_MD0);
      md("b2b_c1", 1'b0, 1'b0, E_MDB);
      md("b2b_c2", 1'b0, 1'b0, E_MDB);
      md("b2b_c3_done", 1'b0, 1'b0, E_DONE);
      idle("b2b_after", 1'b0, E_NONE);

      // Reset mid-BUSY, MULDIV_CYCLES=8
      step("rst8_pre", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
      idle("rst8_rel", 1'b1, E_NONE);
      md("md8_c0", 1'b1, 1'b0, E_MD0);
      md("md8_c1", 1'b1, 1'b0, E_MDB);
      md("md8_c2", 1'b1, 1'b0, E_MDB);
      step("md8_c3_rst", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_NONE);
      for (int i = 0; i < 10; i++)
         idle("md8_after_rst", 1'b1, E_NONE);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Central pipeline hazard controller for the 5-stage core. It drives the `stall_i`/`flush_i` pins of the four `riscv_pipe` stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold. It resolves load-use, taken-branch, multi-cycle mul/div and data-memory-wait hazards. It also keeps a saturating stall-cycle counter.

## Interface
- `MULDIV_CYCLES`, default 32: total cycles a mul/div instruction occupies EX; legal range 2..255.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `id_rs1_i`, `id_rs2_i` in 5 each: source register indices of the instruction in ID.
- `id_rs1_used_i`, `id_rs2_used_i` in 1 each: the ID instruction actually reads rs1 / rs2.
- `ex_rd_i` in 5: destination register of the instruction in EX.
- `ex_is_load_i` in 1: the instruction in EX is a load.
- `ex_muldiv_i` in 1: the instruction in EX is mul/div/rem.
- `ex_redirect_i` in 1: taken branch or jump resolved in EX.
- `mem_busy_i` in 1: data memory has not completed the MEM-stage access.
- `pc_stall_o` out 1: PC holds its value. The PC ignores the redirect while this is high.
- `stall_ifid_o`, `flush_ifid_o` out 1 each: IF/ID register control.
- `stall_idex_o`, `flush_idex_o` out 1 each: ID/EX register control.
- `stall_exmem_o`, `flush_exmem_o` out 1 each: EX/MEM register control.
- `stall_memwb_o`, `flush_memwb_o` out 1 each: MEM/WB register control.
- `md_busy_o` out 1: mul/div FSM is in BUSY.
- `md_done_o` out 1: final EX cycle of a mul/div; the result is valid.
- `stall_cnt_o` out 32: count of cycles with `pc_stall_o` high; saturates at 0xFFFFFFFF.

## Operation
- The stage registers give stall priority over flush. This block therefore never asserts stall and flush together on the same register.
- Hazard detect:
  - `lu_haz` = `ex_is_load_i` & `ex_rd_i`≠0 & ((`id_rs1_used_i` & rs1==rd) | (`id_rs2_used_i` & rs2==rd)).
  - `md_haz` is defined below.
- Priority, highest first. Outputs not listed are 0.
  1. `mem_busy_i`: stall PC, IF/ID, ID/EX and EX/MEM; flush MEM/WB. `ex_redirect_i` is ignored and stays pending because EX is frozen. The mul/div FSM and counter hold.
  2. `md_haz`: stall PC, IF/ID and ID/EX; flush EX/MEM.
  3. `ex_redirect_i`: flush IF/ID and ID/EX; no stall.
  4. `lu_haz`: stall PC and IF/ID; flush ID/EX (one bubble).
- Mul/div FSM has two states, IDLE and BUSY, with an 8-bit down-counter `cnt`.
  - IDLE with `ex_muldiv_i` (and no `mem_busy_i`): `md_haz`=1, `cnt`←MULDIV_CYCLES−2, go to BUSY.
  - BUSY, `cnt`≠0: `md_haz`=1, `cnt`←`cnt`−1.
  - BUSY, `cnt`=0: `md_haz`=0, `md_done_o`=1, go to IDLE.
  - Net effect: a mul/div stays in EX for exactly MULDIV_CYCLES cycles when memory is not busy.
  - A back-to-back mul/div starts in the cycle after `md_done_o`.
  - `md_busy_o` = (state==BUSY).
- `stall_cnt_o` increments on every clock edge where `pc_stall_o`=1 and the count is below 0xFFFFFFFF.
- All stall/flush outputs are combinational from the inputs and FSM state. They are forced to 0 while `rst_i`=0.

## Timing
- Reset (`rst_i`=0, asynchronous):
  - state=IDLE, `cnt`=0, `stall_cnt_o`=0.
  - All stall/flush outputs, `md_busy_o` and `md_done_o` are 0.
  - Release takes effect at the first rising edge after deassertion.
- Reset mid-BUSY aborts the mul/div. The FSM is in IDLE on the next cycle; there is no `md_done_o` pulse.
- Latency:
  - Hazard outputs are valid in the same cycle as their inputs (0 cycles).
  - FSM and `stall_cnt_o` update 1 cycle after the qualifying edge.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM, so `lu_haz` drops.
- Redirect costs 2 bubbles (IF/ID and ID/EX flushed in the same cycle).
- `mem_busy_i` arriving during BUSY:
  - Freeze has priority.
  - `cnt` holds and `md_done_o` is suppressed until `mem_busy_i` drops.
  - Total EX occupancy = MULDIV_CYCLES + busy cycles.
- `mem_busy_i` together with `ex_redirect_i`: no flush while busy. The flush occurs in the first cycle after `mem_busy_i`=0.
- `ex_redirect_i` together with `lu_haz`: the redirect wins. The ID instruction is flushed, so no stall is needed.
- `stall_cnt_o` at 0xFFFFFFFF stays at 0xFFFFFFFF.

## Test plan
- Load-use: `ex_is_load_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_rs2_used_i`=1 for 1 cycle → same cycle `pc_stall_o`=`stall_ifid_o`=`flush_idex_o`=1 and all other outputs 0; `stall_cnt_o`=1 on the next cycle. Repeat with `ex_rd_i`=0 → no stall.
- Redirect: `ex_redirect_i`=1 → `flush_ifid_o`=`flush_idex_o`=1 and all stalls 0. With `lu_haz` also true → same response and `pc_stall_o`=0.
- Mul/div, MULDIV_CYCLES=4: hold `ex_muldiv_i`=1 → `md_haz` stalls in cycles 0–2 with `flush_exmem_o`=1; cycle 3 `md_done_o`=1 and no stall. `md_busy_o` is high in cycles 1–3. `stall_cnt_o`=3 afterwards.
- Memory wait during mul/div: MULDIV_CYCLES=4, `mem_busy_i`=1 for 2 cycles starting at cycle 1 → `stall_exmem_o`=`flush_memwb_o`=1 in those cycles and `cnt` holds; `md_done_o` arrives at cycle 5.
- Memory wait + redirect: `mem_busy_i`=1 for 3 cycles with `ex_redirect_i`=1 throughout → no flush for 3 cycles; on cycle 4 `flush_ifid_o`=`flush_idex_o`=1.
- Reset mid-BUSY: MULDIV_CYCLES=8, drive `rst_i`=0 at cycle 3 → outputs 0 immediately (asynchronously), `stall_cnt_o`=0, `md_busy_o`=0; no `md_done_o` after release.
